// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I definitions for the decode stage: opcode
//               constants, ALU and result-select encodings, the NOP word,
//               the ID/EX control bundle and the ALU-operation decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] c_nop = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_src_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        illegal;
        result_src_e result_src;
        alu_ctrl_e   alu_control;
    } idex_ctrl_t;

    // funct3 -> ALU op for OP / OP-IMM. Bit 30 selects SUB only for
    // register-register forms; it selects SRA for both forms.
    function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3,
                                             input logic       alt,
                                             input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 32 x XLEN integer register file, two combinational read
//               ports, one write port with same-cycle write-to-read bypass.
//               x0 reads as zero. Asynchronous active-low clear.
// Ports       : clk, reset (active low), i_ra1/i_ra2 read indices,
//               i_we/i_wa/i_wd write port, o_rd1/o_rd2 read data.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    logic            wr_en;

    assign wr_en = i_we && (i_wa != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[i_wa] = i_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass lets the writeback value reach decode in the same cycle it is
    // being written, so the pipeline needs no WB->ID forwarding path.
    always_comb begin
        o_rd1 = regs_q[i_ra1];
        o_rd2 = regs_q[i_ra2];
        if (wr_en && (i_wa == i_ra1)) o_rd1 = i_wd;
        if (wr_en && (i_wa == i_ra2)) o_rd2 = i_wd;
        if (i_ra1 == 5'd0)            o_rd1 = '0;
        if (i_ra2 == 5'd0)            o_rd2 = '0;
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode stage. IF/ID register with stall/flush,
//               instruction decoder, immediate generator, register file and
//               the ID/EX register (flushable, never stalled).
// Ports       : clk, reset (async, active low); PCF/InstrF from fetch;
//               StallD/FlushD/FlushE from the hazard unit; RegWriteW/RdW/
//               ResultW writeback port; Rs1D/Rs2D combinational source
//               indices; *E outputs are the registered ID/EX bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    input  logic [31:0]     InstrF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            JalrE,
    output logic            ALUSrcAE,
    output logic            ALUSrcBE,
    output logic            IllegalE,
    output logic [1:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic [2:0]      Funct3E
);

    // ---------------- IF/ID register ----------------
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;

    // Flush wins over stall; a flush keeps the PC and only replaces the word.
    always_comb begin
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if (FlushD) begin
            if_instr_d = c_nop;
        end else if (!StallD) begin
            if_pc_d    = PCF;
            if_instr_d = InstrF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_pc_q    <= RESET_PC;
            if_instr_q <= c_nop;
        end else begin
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // ---------------- decoder ----------------
    logic [6:0]  opcode;
    logic [31:0] instr;
    idex_ctrl_t  ctrl;
    imm_src_e    imm_src;
    logic [31:0] imm32;
    logic [XLEN-1:0] imm_ext;

    assign instr  = if_instr_q;
    assign opcode = instr[6:0];

    // LUI carries immediate bits in the rs1 field; zero it so the hazard unit
    // sees no false dependency.
    assign Rs1D = (opcode == c_op_lui) ? 5'd0 : instr[19:15];
    assign Rs2D = instr[24:20];

    always_comb begin
        ctrl             = '0;
        ctrl.result_src  = RES_ALU;
        ctrl.alu_control = ALU_ADD;
        imm_src          = IMM_NONE;
        case (opcode)
            c_op_lui: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = ALU_PASS_B;
                imm_src          = IMM_U;
            end
            c_op_auipc: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm_src        = IMM_U;
            end
            c_op_jal: begin
                // ALU forms PC+imm, which is the JAL target
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            c_op_jalr: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_I;
            end
            c_op_branch: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
                imm_src          = IMM_B;
            end
            c_op_load: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_MEM;
                imm_src         = IMM_I;
            end
            c_op_store: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm_src        = IMM_S;
            end
            c_op_imm: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = alu_decode(instr[14:12], instr[30], 1'b0);
                imm_src          = IMM_I;
            end
            c_op_reg: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = alu_decode(instr[14:12], instr[30], 1'b1);
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

    // ---------------- immediate generator ----------------
    always_comb begin
        case (imm_src)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'(signed'(imm32));
    end

    // ---------------- register file ----------------
    logic [XLEN-1:0] rf_rd1, rf_rd2;

    register_file #(
        .XLEN (XLEN)
    ) u_register_file (
        .clk   (clk),
        .reset (reset),
        .i_ra1 (Rs1D),
        .i_ra2 (Rs2D),
        .i_we  (RegWriteW),
        .i_wa  (RdW),
        .i_wd  (ResultW),
        .o_rd1 (rf_rd1),
        .o_rd2 (rf_rd2)
    );

    // ---------------- ID/EX register ----------------
    idex_ctrl_t      ex_ctrl_q, ex_ctrl_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_rd1_q, ex_rd1_d;
    logic [XLEN-1:0] ex_rd2_q, ex_rd2_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]      ex_rs1_q, ex_rs1_d;
    logic [4:0]      ex_rs2_q, ex_rs2_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic [2:0]      ex_funct3_q, ex_funct3_d;

    always_comb begin
        ex_ctrl_d   = ctrl;
        ex_pc_d     = if_pc_q;
        ex_rd1_d    = rf_rd1;
        ex_rd2_d    = rf_rd2;
        ex_imm_d    = imm_ext;
        ex_rs1_d    = Rs1D;
        ex_rs2_d    = Rs2D;
        ex_rd_d     = instr[11:7];
        ex_funct3_d = instr[14:12];
        if (FlushE) begin
            ex_ctrl_d   = '0;
            ex_pc_d     = RESET_PC;
            ex_rd1_d    = '0;
            ex_rd2_d    = '0;
            ex_imm_d    = '0;
            ex_rs1_d    = '0;
            ex_rs2_d    = '0;
            ex_rd_d     = '0;
            ex_funct3_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl_q   <= '0;
            ex_pc_q     <= RESET_PC;
            ex_rd1_q    <= '0;
            ex_rd2_q    <= '0;
            ex_imm_q    <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            ex_funct3_q <= '0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            ex_pc_q     <= ex_pc_d;
            ex_rd1_q    <= ex_rd1_d;
            ex_rd2_q    <= ex_rd2_d;
            ex_imm_q    <= ex_imm_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            ex_funct3_q <= ex_funct3_d;
        end
    end

    assign PCE         = ex_pc_q;
    assign RD1E        = ex_rd1_q;
    assign RD2E        = ex_rd2_q;
    assign ImmExtE     = ex_imm_q;
    assign Rs1E        = ex_rs1_q;
    assign Rs2E        = ex_rs2_q;
    assign RdE         = ex_rd_q;
    assign Funct3E     = ex_funct3_q;
    assign RegWriteE   = ex_ctrl_q.reg_write;
    assign MemWriteE   = ex_ctrl_q.mem_write;
    assign BranchE     = ex_ctrl_q.branch;
    assign JumpE       = ex_ctrl_q.jump;
    assign JalrE       = ex_ctrl_q.jalr;
    assign ALUSrcAE    = ex_ctrl_q.alu_src_a;
    assign ALUSrcBE    = ex_ctrl_q.alu_src_b;
    assign IllegalE    = ex_ctrl_q.illegal;
    assign ResultSrcE  = ex_ctrl_q.result_src;
    assign ALUControlE = ex_ctrl_q.alu_control;

endmodule
`default_nettype wire
